fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/riscv_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 75 +++++++
 rtl/fetch_stage.sv | 104 ++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types: fetch buffer entry, NOP encoding, reset PC
// and the decode control bundle.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_OR,
    ALU_AND
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    alu_src;
    alu_op_e alu_op;
  } control_signals_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage, occupancy count and a
// synchronous clear that empties it in one cycle.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    // A push into a full FIFO is only legal when the head leaves this cycle.
    do_push  = push_i && (!full_o || pop_i);
    do_pop   = pop_i && !empty_o;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: issues sequential requests to instruction memory under a
// credit limit, buffers in-order responses and squashes stale ones on redirect.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        instr_ready_i
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;

  logic [CW:0]   in_flight;
  logic [31:0]   redirect_target;
  logic          issue, rsp_live, rsp_drop, push, pop;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  push_entry, head_entry;

  assign imem_addr_o = pc_q;

  always_comb begin
    redirect_target = {redirect_pc_i[31:2], 2'b00};
    // Credits use the pre-pop occupancy so a pop never frees a slot the same cycle.
    in_flight  = {1'b0, outstanding_q} + {1'b0, fifo_count};
    imem_req_o = !rst_i && !redirect_i && (in_flight < (CW+1)'(DEPTH));
    issue      = imem_req_o && imem_gnt_i;
    rsp_live   = imem_rvalid_i && (outstanding_q != '0);
    rsp_drop   = rsp_live && (discard_q != '0);
    push       = rsp_live && !rsp_drop && !redirect_i && !rst_i;
    push_entry = '{pc: resp_pc_q, instr: imem_rdata_i};

    instr_valid_o = !fifo_empty && !rst_i;
    instr_o       = instr_valid_o ? head_entry.instr : NOP_INSTR;
    pc_o          = instr_valid_o ? head_entry.pc : 32'h0;
    pop           = instr_valid_o && instr_ready_i && !redirect_i;

    pc_d          = issue ? pc_q + 32'd4 : pc_q;
    resp_pc_d     = push ? resp_pc_q + 32'd4 : resp_pc_q;
    outstanding_d = outstanding_q + CW'(issue) - CW'(rsp_live);
    discard_d     = discard_q - CW'(rsp_drop);
    if (redirect_i) begin
      // Everything still in flight belongs to the wrong path.
      pc_d          = redirect_target;
      resp_pc_d     = redirect_target;
      outstanding_d = outstanding_q - CW'(rsp_live);
      discard_d     = outstanding_q - CW'(rsp_live);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (redirect_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_entry),
    .rdata_o (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && fifo_full && !pop));
  a_outstanding_bound : assert property (@(posedge clk_i) disable iff (rst_i)
    outstanding_q <= CW'(DEPTH));

endmodule
